seven_seg_mux: RTL
==================

# seven_seg_mux

Parametrised, time-multiplexed seven-segment driver for N-digit common-anode/cathode displays. It is the successor of the fixed 8-digit hex scanner. It adds configurable digit count and polarity, per-digit decimal points, PWM brightness within each digit slot, and frame-coherent input snapshotting so that values never tear mid-scan. It sits between the result/status logic and the board display pins, paced by an external clock-enable strobe.

## Interface
- DIGITS, 8: number of digits scanned, 1..16; need not be a power of two.
- PWM_BITS, 4: brightness resolution; each digit slot lasts 2^PWM_BITS ce pulses.
- ANODE_ACTIVE_LOW, 1: 1 means an anode is driven 0 when lit.
- SEG_ACTIVE_LOW, 1: 1 means a segment or dp is driven 0 when lit.

- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  scan-step strobe, one clk wide; all state advances only on ce.
- digits  in  4*DIGITS  hex nibbles; digit i is bits [4i+3:4i].
- dots  in  DIGITS  decimal point enable per digit.
- anodes_mask  in  DIGITS  1 means the digit is enabled; 0 keeps it dark.
- brightness  in  PWM_BITS  duty control; 0 is dark, all-ones is fully on.
- anodes  out  DIGITS  digit select, polarity per ANODE_ACTIVE_LOW.
- segments  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW.
- frame_start  out  1  one-clk pulse when a snapshot is taken.

## Operation
- Counters: sub = PWM_BITS-bit slot counter; idx = digit index, 0..DIGITS-1. On ce, sub increments. When sub wraps from all-ones to 0, idx increments. idx wraps from DIGITS-1 to 0; it never takes a value of DIGITS or more.
- Snapshot: on a ce with idx==0 and sub==0, latch digits, dots, anodes_mask and brightness into shadow registers, and pulse frame_start. That same ce's output uses the newly latched values via a bypass. All other slots use only the shadow values.
- Output decode, on each ce, using the pre-increment idx and sub:
  - Encode the hex glyph of nibble idx. Glyphs a–f are the standard seven-segment forms A, b, C, d, E, F.
  - lit = mask[idx] AND (sub < brightness OR brightness == all-ones).
  - If lit: drive the selected anode active and all others inactive; drive segments with the glyph and dp = dots[idx].
  - If not lit: drive all anodes inactive; segments and dp are also driven inactive.
- Outputs hold between ce pulses.
- Polarity is applied at the output register only.

## Timing
- Reset clears sub, idx and all shadows to 0, and drives frame_start to 0.
- During reset, all anodes, segments and dp are driven to their inactive level. Inactive means all-ones when the corresponding active-low parameter is 1.
- Reset mid-frame aborts the scan. The first ce after reset is a frame start.
- Latency: outputs change on the clk edge that samples ce=1, one register stage from the shadow values.
- Frame length: DIGITS × 2^PWM_BITS ce pulses. Digit slot: 2^PWM_BITS ce pulses.
- Input changes mid-frame are not visible until the next frame start.
- If rst and ce are both high, rst wins.
- If ce is held high continuously, the block advances every clk; this is legal.

## Configuration
- SEVEN_SEG_MUX_LZB_EN: when defined, leading-zero blanking is compiled in.
  - A digit is treated as not lit when its nibble and all higher-index nibbles in the snapshot are 0, and its dot bit is 0.
  - Digit 0 is never blanked this way.
  - The blank map is computed once per snapshot and registered alongside the shadows.
- When the macro is not defined, zero nibbles display "0" normally and no blank-map logic exists.

## Structure
- The shared package holds:
  - the 16-entry active-high glyph constant table;
  - a glyph-encode function;
  - localparams for the default DIGITS and PWM_BITS.
- One sub-module, seven_seg_scan_ctr, holds the sub/idx counters, the wrap and frame-start logic, and the snapshot-enable output.
- The top level holds the shadows, decode, PWM compare and output registers.

## Test plan
- Reset check: DIGITS=8, defaults, rst asserted.
  - anodes=8'hFF, segments=7'h7F, dp=1, frame_start=0.
  - The first ce after release produces frame_start=1.
- Basic scan: digits=32'h76543210, mask=8'hFF, brightness=all-ones.
  - Slot k selects anode ~(1<<k) for 16 ce pulses.
  - Slot 0 segments=7'b1000000; slot 7 segments=7'b1111000.
- Non-power-of-two width: DIGITS=6.
  - idx sequence is 0..5 then 0.
  - frame_start occurs every 96 ce pulses.
  - anodes never has a bit 6 or higher active.
- PWM: brightness=4'd5, mask=1.
  - Digit 0 is lit for sub=0..4 and dark for sub=5..15.
  - brightness=0 keeps the display dark for the whole frame.
- Tear-free update: change digits from 32'h11111111 to 32'h22222222 at slot 3 of a frame.
  - All 8 digits show "1" through the end of that frame.
  - All show "2" from the next frame_start.
- LZB build: digits=32'h00000905, dots=0.
  - Digits 7..3 are dark; digits 2, 1 and 0 show 9, 0, 5.
  - Setting dots[4]=1 lights digit 4 as "0." in the next frame.

Source files
------------

// File: rtl/seven_seg_mux_pkg.sv
// Shared definitions for the seven-segment scanner: default geometry, the
// active-high hex glyph table and its encode function.
package seven_seg_mux_pkg;

  localparam int DEFAULT_DIGITS   = 8;
  localparam int DEFAULT_PWM_BITS = 4;

  // Segment order within a glyph is {g,f,e,d,c,b,a}; 1 means the segment is lit.
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F,  // 0
    7'h06,  // 1
    7'h5B,  // 2
    7'h4F,  // 3
    7'h66,  // 4
    7'h6D,  // 5
    7'h7D,  // 6
    7'h07,  // 7
    7'h7F,  // 8
    7'h6F,  // 9
    7'h77,  // A
    7'h7C,  // b
    7'h39,  // C
    7'h5E,  // d
    7'h79,  // E
    7'h71   // F
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    return GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctr.sv
// Slot/digit scan counters for seven_seg_mux: sub counts ce pulses inside a
// digit slot, idx walks the digits, and a snapshot strobe marks each frame start.
module seven_seg_scan_ctr #(
  parameter int DIGITS   = 8,
  parameter int PWM_BITS = 4,
  parameter int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  output logic [PWM_BITS-1:0] sub,
  output logic [IDX_W-1:0]    idx,
  output logic                snap_en,
  output logic                frame_start
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic sub_wrap;
  logic idx_wrap;

  assign sub_wrap = &sub;
  assign idx_wrap = (idx == IDX_LAST);

  // The snapshot happens on the ce that sits at the very first slot of a frame.
  assign snap_en = ce && (idx == '0) && (sub == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub <= '0;
      idx <= '0;
    end else if (ce) begin
      sub <= sub + 1'b1;
      if (sub_wrap) begin
        idx <= idx_wrap ? '0 : idx + 1'b1;
      end
    end
  end

  // One clk wide: follows the strobe every clk, not only on ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap_en;
    end
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed N-digit seven-segment driver with per-digit dots, PWM
// brightness and frame-coherent input snapshots. Optional leading-zero
// blanking is compiled in when SEVEN_SEG_MUX_LZB_EN is defined.
module seven_seg_mux
  import seven_seg_mux_pkg::*;
#(
  parameter int DIGITS           = DEFAULT_DIGITS,
  parameter int PWM_BITS         = DEFAULT_PWM_BITS,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [4*DIGITS-1:0] digits,
  input  logic [DIGITS-1:0]   dots,
  input  logic [DIGITS-1:0]   anodes_mask,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [DIGITS-1:0]   anodes,
  output logic [6:0]          segments,
  output logic                dp,
  output logic                frame_start
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Inactive levels double as XOR masks that convert active-high to pin polarity.
  localparam logic [DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF    = (SEG_ACTIVE_LOW != 0);

  logic [PWM_BITS-1:0] sub;
  logic [IDX_W-1:0]    idx;
  logic                snap_en;

  seven_seg_scan_ctr #(
    .DIGITS   (DIGITS),
    .PWM_BITS (PWM_BITS),
    .IDX_W    (IDX_W)
  ) u_scan_ctr (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .sub         (sub),
    .idx         (idx),
    .snap_en     (snap_en),
    .frame_start (frame_start)
  );

  // Frame snapshot of the display inputs.
  logic [4*DIGITS-1:0] sh_digits;
  logic [DIGITS-1:0]   sh_dots;
  logic [DIGITS-1:0]   sh_mask;
  logic [PWM_BITS-1:0] sh_bright;

  // NOTE: the shadows are a handful of flops, not a RAM, so they are reset;
  // a frame aborted by reset must restart from a known blank state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_digits <= '0;
      sh_dots   <= '0;
      sh_mask   <= '0;
      sh_bright <= '0;
    end else if (snap_en) begin
      sh_digits <= digits;
      sh_dots   <= dots;
      sh_mask   <= anodes_mask;
      sh_bright <= brightness;
    end
  end

  // The frame-start slot bypasses the shadows so it shows the freshly latched values.
  logic [4*DIGITS-1:0] eff_digits;
  logic [DIGITS-1:0]   eff_dots;
  logic [DIGITS-1:0]   eff_mask;
  logic [PWM_BITS-1:0] eff_bright;

  assign eff_digits = snap_en ? digits      : sh_digits;
  assign eff_dots   = snap_en ? dots        : sh_dots;
  assign eff_mask   = snap_en ? anodes_mask : sh_mask;
  assign eff_bright = snap_en ? brightness  : sh_bright;

`ifdef SEVEN_SEG_MUX_LZB_EN
  // A digit above 0 is blanked while it and every higher nibble are zero and its dot is off.
  logic [DIGITS-1:0] blank_next;
  logic [DIGITS-1:0] sh_blank;
  logic [DIGITS-1:0] eff_blank;
  logic              zero_above;

  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (digits[4*i +: 4] == 4'h0);
      blank_next[i] = zero_above && !dots[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_blank <= '0;
    end else if (snap_en) begin
      sh_blank <= blank_next;
    end
  end

  assign eff_blank = snap_en ? blank_next : sh_blank;
`endif

  logic [3:0]        nibble;
  logic              pwm_on;
  logic              lit;
  logic [DIGITS-1:0] sel;
  logic [DIGITS-1:0] anode_on;
  logic [6:0]        seg_on;
  logic              dp_on;

  // NOTE: every combinational output gets a default first, so no path
  // through the block can leave a value held and infer a latch.
  always_comb begin
    nibble   = eff_digits[int'(idx)*4 +: 4];
    pwm_on   = (sub < eff_bright) || (&eff_bright);
    lit      = eff_mask[idx] && pwm_on;
`ifdef SEVEN_SEG_MUX_LZB_EN
    lit      = lit && !eff_blank[idx];
`endif
    sel      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sel[i] = (int'(idx) == i);
    end
    anode_on = lit ? sel : '0;
    seg_on   = lit ? hex_glyph(nibble) : 7'h00;
    dp_on    = lit && eff_dots[idx];
  end

  // Pin polarity is applied only here; everything upstream is active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      anodes   <= ANODE_OFF;
      segments <= SEG_OFF;
      dp       <= DP_OFF;
    end else if (ce) begin
      anodes   <= anode_on ^ ANODE_OFF;
      segments <= seg_on ^ SEG_OFF;
      dp       <= dp_on ^ DP_OFF;
    end
  end

endmodule
